// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: pattern modes and ping-pong direction.
package led_seq_pkg;

    localparam logic [1:0] MODE_SHIFT    = 2'd0;
    localparam logic [1:0] MODE_PINGPONG = 2'd1;
    localparam logic [1:0] MODE_MIRROR   = 2'd2;
    localparam logic [1:0] MODE_BLINK    = 2'd3;

    typedef enum logic {
        BOUNCE_UP   = 1'b0,
        BOUNCE_DOWN = 1'b1
    } bounce_e;

endpackage

// File: rtl/led_pattern_seq_tick_prescaler.sv
// Free-running step prescaler: one combinational tick every i_limit+1 enabled cycles.
module tick_prescaler #(
    parameter int PRESC_W = 32
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic [PRESC_W-1:0] i_limit,
    output logic               o_tick
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    // '>=' rather than '==' so a limit lowered below the running count ticks at once.
    always_comb begin
        cnt_d  = cnt_q;
        o_tick = 1'b0;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            if (cnt_q >= i_limit) begin
                cnt_d  = '0;
                o_tick = 1'b1;
            end else begin
                cnt_d = cnt_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED bank sequencer: shift, ping-pong, mirror and blink patterns advanced by a prescaled tick.
module led_pattern_seq #(
    parameter int N_LEDS  = 4,
    parameter int PRESC_W = 32
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_dir,
    input  logic [1:0]         i_mode,
    input  logic [PRESC_W-1:0] i_limit,
    output logic [N_LEDS-1:0]  o_leds,
    output logic               o_tick,
    output logic               o_wrap
);

    import led_seq_pkg::*;

    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int HALF  = (N_LEDS + 1) / 2;
    localparam logic [POS_W-1:0] POS_LAST      = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_HALF_LAST = POS_W'(HALF - 1);

    if (N_LEDS < 2) begin : g_bad_n_leds
        $error("led_pattern_seq: N_LEDS must be at least 2");
    end

    logic [1:0]        mode_q, mode_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    bounce_e           bounce_q, bounce_d;
    logic              phase_q, phase_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              tick_q, tick_d;
    logic              wrap_q, wrap_d;
    logic              mode_change;
    logic              step;

    assign mode_change = (i_mode != mode_q);

    tick_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_clear  (mode_change),
        .i_limit  (i_limit),
        .o_tick   (step)
    );

    // The LED register always shows the state as it stood before this edge.
    always_comb begin
        leds_d = '0;
        case (mode_q)
            MODE_SHIFT, MODE_PINGPONG: leds_d[pos_q] = 1'b1;
            MODE_MIRROR: begin
                leds_d[pos_q]            = 1'b1;
                leds_d[POS_LAST - pos_q] = 1'b1;
            end
            default: leds_d = phase_q ? '0 : '1;
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        pos_d    = pos_q;
        bounce_d = bounce_q;
        phase_d  = phase_q;
        tick_d   = step;
        wrap_d   = 1'b0;
        if (mode_change) begin
            mode_d   = i_mode;
            pos_d    = '0;
            bounce_d = BOUNCE_UP;
            phase_d  = 1'b0;
        end else if (step) begin
            case (mode_q)
                MODE_SHIFT: begin
                    if (i_dir) begin
                        wrap_d = (pos_q == POS_LAST);
                        pos_d  = wrap_d ? '0 : pos_q + POS_W'(1);
                    end else begin
                        wrap_d = (pos_q == '0);
                        pos_d  = wrap_d ? POS_LAST : pos_q - POS_W'(1);
                    end
                end
                MODE_PINGPONG: begin
                    if (bounce_q == BOUNCE_UP) begin
                        pos_d = pos_q + POS_W'(1);
                        if (pos_d == POS_LAST) bounce_d = BOUNCE_DOWN;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                        if (pos_d == '0) begin
                            bounce_d = BOUNCE_UP;
                            wrap_d   = 1'b1;
                        end
                    end
                end
                MODE_MIRROR: begin
                    if (i_dir) begin
                        wrap_d = (pos_q == POS_HALF_LAST);
                        pos_d  = wrap_d ? '0 : pos_q + POS_W'(1);
                    end else begin
                        wrap_d = (pos_q == '0);
                        pos_d  = wrap_d ? POS_HALF_LAST : pos_q - POS_W'(1);
                    end
                end
                default: begin
                    wrap_d  = phase_q;
                    phase_d = ~phase_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            mode_q   <= MODE_SHIFT;
            pos_q    <= '0;
            bounce_q <= BOUNCE_UP;
            phase_q  <= 1'b0;
            leds_q   <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pos_q    <= pos_d;
            bounce_q <= bounce_d;
            phase_q  <= phase_d;
            leds_q   <= leds_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    assign o_leds = leds_q;
    assign o_tick = tick_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: 4-LED and 5-LED instances share stimulus and are checked
// against a pattern model plus a table of hand-derived vectors.
module tb_led_pattern_seq;

    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic          i_dir;
    logic [1:0]    i_mode;
    logic [PW-1:0] i_limit;

    logic [3:0] leds4;
    logic       tick4, wrap4;
    logic [4:0] leds5;
    logic       tick5, wrap5;

    int compared   = 0;
    int mismatched = 0;

    // Model state per instance: index 0 is the 4-LED bank, index 1 the 5-LED bank.
    int         m_cnt   [2];
    int         m_mode  [2];
    int         m_idx   [2];
    int         m_phase [2];
    logic [7:0] m_leds  [2];
    logic       m_tick  [2];
    logic       m_wrap  [2];

    typedef struct {
        logic       rst;
        logic       en;
        logic       dir;
        logic [1:0] mode;
        logic [7:0] limit;
        logic [3:0] leds;
        logic       tick;
        logic       wrap;
    } vec_t;

    vec_t vecs [14];

    led_pattern_seq #(.N_LEDS(4), .PRESC_W(PW)) dut4 (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_dir    (i_dir),
        .i_mode   (i_mode),
        .i_limit  (i_limit),
        .o_leds   (leds4),
        .o_tick   (tick4),
        .o_wrap   (wrap4)
    );

    led_pattern_seq #(.N_LEDS(5), .PRESC_W(PW)) dut5 (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_dir    (i_dir),
        .i_mode   (i_mode),
        .i_limit  (i_limit),
        .o_leds   (leds5),
        .o_tick   (tick5),
        .o_wrap   (wrap5)
    );

    always #5 clock = ~clock;

    // Pattern from the abstract state; ping-pong index runs 0..2n-3 around the bounce.
    function automatic logic [7:0] pattern_of(int n, int mode, int idx, int phase);
        int v;
        int pos;
        v = 0;
        case (mode)
            0: v = 1 << idx;
            1: begin
                pos = (idx < n) ? idx : (2 * n - 2 - idx);
                v   = 1 << pos;
            end
            2: v = (1 << idx) | (1 << (n - 1 - idx));
            default: v = (phase == 0) ? ((1 << n) - 1) : 0;
        endcase
        return v[7:0];
    endfunction

    task automatic model_edge();
        int n;
        int h;
        int len;
        for (int k = 0; k < 2; k++) begin
            n   = (k == 0) ? 4 : 5;
            h   = (n + 1) / 2;
            len = 2 * n - 2;
            if (i_reset) begin
                m_cnt[k]   = 0;
                m_mode[k]  = 0;
                m_idx[k]   = 0;
                m_phase[k] = 0;
                m_leds[k]  = 8'h00;
                m_tick[k]  = 1'b0;
                m_wrap[k]  = 1'b0;
            end else begin
                m_leds[k] = pattern_of(n, m_mode[k], m_idx[k], m_phase[k]);
                m_tick[k] = 1'b0;
                m_wrap[k] = 1'b0;
                if (int'(i_mode) != m_mode[k]) begin
                    m_mode[k]  = int'(i_mode);
                    m_idx[k]   = 0;
                    m_phase[k] = 0;
                    m_cnt[k]   = 0;
                end else if (i_enable) begin
                    if (m_cnt[k] >= int'(i_limit)) begin
                        m_cnt[k]  = 0;
                        m_tick[k] = 1'b1;
                        case (m_mode[k])
                            0: begin
                                if (i_dir) begin
                                    m_idx[k]  = (m_idx[k] + 1) % n;
                                    m_wrap[k] = (m_idx[k] == 0);
                                end else begin
                                    m_wrap[k] = (m_idx[k] == 0);
                                    m_idx[k]  = (m_idx[k] + n - 1) % n;
                                end
                            end
                            1: begin
                                m_idx[k]  = (m_idx[k] + 1) % len;
                                m_wrap[k] = (m_idx[k] == 0);
                            end
                            2: begin
                                if (i_dir) begin
                                    m_idx[k]  = (m_idx[k] + 1) % h;
                                    m_wrap[k] = (m_idx[k] == 0);
                                end else begin
                                    m_wrap[k] = (m_idx[k] == 0);
                                    m_idx[k]  = (m_idx[k] + h - 1) % h;
                                end
                            end
                            default: begin
                                m_wrap[k]  = (m_phase[k] == 1);
                                m_phase[k] = 1 - m_phase[k];
                            end
                        endcase
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic en, input logic dir,
                                  input logic [1:0] mode, input logic [PW-1:0] limit);
        i_reset  = rst;
        i_enable = en;
        i_dir    = dir;
        i_mode   = mode;
        i_limit  = limit;
    endtask

    task automatic run_cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_output("leds4", 32'(leds4), 32'(m_leds[0]));
        check_output("tick4", 32'(tick4), 32'(m_tick[0]));
        check_output("wrap4", 32'(wrap4), 32'(m_wrap[0]));
        check_output("leds5", 32'(leds5), 32'(m_leds[1]));
        check_output("tick5", 32'(tick5), 32'(m_tick[1]));
        check_output("wrap5", 32'(wrap5), 32'(m_wrap[1]));
    endtask

    initial begin
        logic [7:0] frozen;

        // SHIFT, dir up, limit 2 from reset: one step every three cycles, wrap on 1000 -> 0001.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0001, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0001, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0001, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0010, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0010, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0010, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0100, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0100, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0100, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b1000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b1000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b1000, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 2'd0, 8'd2, 4'b0001, 1'b0, 1'b0};

        for (int k = 0; k < 2; k++) begin
            m_cnt[k]   = 0;
            m_mode[k]  = 0;
            m_idx[k]   = 0;
            m_phase[k] = 0;
            m_leds[k]  = 8'h00;
            m_tick[k]  = 1'b0;
            m_wrap[k]  = 1'b0;
        end
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'd2);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].limit);
            run_cycle();
            check_output("vec_leds", 32'(leds4), 32'(vecs[i].leds));
            check_output("vec_tick", 32'(tick4), 32'(vecs[i].tick));
            check_output("vec_wrap", 32'(wrap4), 32'(vecs[i].wrap));
        end

        // PINGPONG at full rate with i_dir toggling underneath.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'(i % 2), 2'd1, 8'd0);
            run_cycle();
        end

        // MIRROR outer->inner, then inner->outer.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 1'b1, (i < 8) ? 1'b1 : 1'b0, 2'd2, 8'd0);
            run_cycle();
        end

        // SHIFT to pos 2, then switch to BLINK on a cycle that would also tick.
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'd0, 8'd0);
        run_cycle();
        run_cycle();
        run_cycle();
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'd3, 8'd0);
        run_cycle();
        check_output("modechg_tick", 32'(tick4), 32'd0);
        run_cycle();
        check_output("blink_leds", 32'(leds4), 32'hF);

        // Freeze with enable low after one counted cycle at limit 3.
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'd0, 8'd3);
        run_cycle();
        run_cycle();
        apply_stimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'd3);
        run_cycle();
        frozen = m_leds[0];
        for (int i = 0; i < 9; i++) begin
            run_cycle();
            check_output("frozen_leds", 32'(leds4), 32'(frozen));
            check_output("frozen_tick", 32'(tick4), 32'd0);
        end
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'd0, 8'd3);
        run_cycle();
        run_cycle();
        run_cycle();
        check_output("resume_tick", 32'(tick4), 32'd1);

        // Reset pulse mid-run, then lower the limit below the running count.
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'd2, 8'd9);
        run_cycle();
        run_cycle();
        apply_stimulus(1'b1, 1'b1, 1'b1, 2'd1, 8'd9);
        run_cycle();
        check_output("reset_leds4", 32'(leds4), 32'd0);
        check_output("reset_leds5", 32'(leds5), 32'd0);
        check_output("reset_tick4", 32'(tick4), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'd0, 8'd9);
        for (int i = 0; i < 7; i++) run_cycle();
        apply_stimulus(1'b0, 1'b1, 1'b1, 2'd0, 8'd2);
        run_cycle();
        check_output("limit_drop_tick", 32'(tick4), 32'd1);

        // Random soak against the model.
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus(($urandom_range(0, 199) == 0),
                           ($urandom_range(0, 4) != 0),
                           1'($urandom_range(0, 1)),
                           ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : i_mode,
                           ($urandom_range(0, 19) == 0) ? PW'($urandom_range(0, 4)) : i_limit);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
